uart_rx_8n1: RTL and testbench

Asynchronous serial receiver for 8N1 UART frames on a single input line. It oversamples `rx` with the system clock, finds each start bit, samples the eight data bits LSB-first at bit centres and checks the stop bit. For each good frame it presents the byte with a one-cycle valid strobe. It sits between the board's UART RX pin and the byte-stream consumer (command/frame parser).

---
 rtl/uart_rx_8n1.sv | 144 ++++++++++++++
 tb/tb_uart_rx_8n1.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_8n1.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_rx_8n1
//
// Receiver for 8N1 UART frames: 1 start bit, 8 data bits LSB first, 1 stop
// bit, no parity. The line is oversampled with the system clock. Bits are
// sampled at their centres, and each good frame is presented with a
// one-cycle strobe.
//
// Ports:
//   clk_100M    in   1  system clock, all logic on the rising edge
//   rst         in   1  asynchronous active-low reset (0 = reset)
//   rx          in   1  serial line, idle high, asynchronous to clk_100M
//   byte_valid  out  1  one-cycle strobe, rx_byte holds a new good byte
//   rx_byte     out  8  last received data byte, bit 0 = first bit on line
// ---------------------------------------------------------------------------
module uart_rx_8n1 #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk_100M,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       rst_sync;
  logic             rst_n_int;
  logic             rx_meta;
  logic             rx_s;
  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  // The reset asserts asynchronously, but its release is retimed to the
  // clock. This stops the flops below from leaving reset on different
  // cycles.
  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync[1];

  // Two-flop synchronizer for the asynchronous line. It resets to the idle
  // level (high), so leaving reset does not look like a start edge.
  always_ff @(posedge clk_100M or negedge rst_n_int) begin
    if (!rst_n_int) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM. START waits half a bit to reach the centre of the start bit.
  // Every later sample is then a whole bit period apart, so all samples fall
  // at bit centres. The FSM leaves STOP at the centre of the stop bit, which
  // lets it catch a start edge that follows with no idle gap.
  always_ff @(posedge clk_100M or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'h00;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end

        START: begin
          if (bit_cnt == CNT_HALF) begin
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            // A line that is high again at mid-start was only a glitch.
            state   <= rx_s ? IDLE : DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_cnt == CNT_FULL) begin
            bit_cnt            <= '0;
            shift_reg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_cnt == CNT_FULL) begin
            bit_cnt <= '0;
            state   <= IDLE;
            // A low stop bit is a framing error. The frame is dropped and
            // rx_byte keeps the last good byte.
            if (rx_s) begin
              rx_byte    <= shift_reg;
              byte_valid <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_rx_8n1
//
// Directed frames are driven onto rx at 868 clocks per bit. The bytes each
// frame should deliver are queued when the frame starts. An independent
// monitor pops the queue on every byte_valid strobe and compares the byte.
// A strobe that arrives with nothing queued is an error.
// ---------------------------------------------------------------------------
module tb_uart_rx_8n1;

  localparam int CLKS_PER_BIT = 868;

  logic       clk_100M = 1'b0;
  logic       rst      = 1'b0;
  logic       rx       = 1'b1;
  logic       byte_valid;
  logic [7:0] rx_byte;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  logic [7:0] exp_q[$];

  // 100 MHz system clock
  always #5 clk_100M = ~clk_100M;

  uart_rx_8n1 dut (
    .clk_100M   (clk_100M),
    .rst        (rst),
    .rx         (rx),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte)
  );

  // Central comparison helper: counts every check and reports mismatches
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // One bit period on the line. The level changes on a falling clock edge.
  task automatic driveBit(input logic level);
    @(negedge clk_100M);
    rx = level;
    repeat (CLKS_PER_BIT - 1) @(negedge clk_100M);
  endtask

  // A full frame. A good stop bit queues the byte as an expected strobe.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    if (stop_bit) exp_q.push_back(data);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    driveBit(stop_bit);
  endtask

  // Monitor: each strobe must match the oldest queued byte
  always @(negedge clk_100M) begin
    if (byte_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_strobe: got byte 0x%0h, required no strobe", rx_byte);
      end else begin
        checkOutput("strobe_byte", rx_byte, exp_q.pop_front());
      end
    end
  end

  // Time limit so the run always terminates
  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Hold reset with the line idle. Outputs must stay cleared.
    rst = 1'b0;
    rx  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_100M);
      checkOutput("reset_valid", {31'd0, byte_valid}, 32'd0);
      checkOutput("reset_byte", {24'd0, rx_byte}, 32'h00);
    end
    @(negedge clk_100M);
    rst = 1'b1;
    driveBit(1'b1);
    driveBit(1'b1);

    // Single frame
    applyStimulus(8'hBF, 1'b1);
    checkOutput("pending_bf", exp_q.size(), 32'd0);

    // Back-to-back frame after one idle bit
    driveBit(1'b1);
    applyStimulus(8'h90, 1'b1);
    checkOutput("pending_90", exp_q.size(), 32'd0);
    repeat (100) @(negedge clk_100M);
    checkOutput("hold_90", {24'd0, rx_byte}, 32'h90);
    checkOutput("strobes_after_b2b", pulses, 32'd2);

    // Glitch shorter than half a bit on an idle line
    @(negedge clk_100M);
    rx = 1'b0;
    repeat (200) @(negedge clk_100M);
    rx = 1'b1;
    repeat (600) @(negedge clk_100M);
    checkOutput("strobes_after_glitch", pulses, 32'd2);
    applyStimulus(8'h55, 1'b1);
    checkOutput("pending_55", exp_q.size(), 32'd0);
    driveBit(1'b1);

    // Framing error: a low stop bit drops the frame
    applyStimulus(8'hA5, 1'b0);
    driveBit(1'b1);
    driveBit(1'b1);
    checkOutput("strobes_after_framing", pulses, 32'd3);
    checkOutput("byte_kept_55", {24'd0, rx_byte}, 32'h55);
    applyStimulus(8'h3C, 1'b1);
    checkOutput("pending_3c", exp_q.size(), 32'd0);
    checkOutput("byte_3c", {24'd0, rx_byte}, 32'h3C);
    driveBit(1'b1);

    // Reset asserted between clock edges during data bit 4
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(1'b1);
    @(negedge clk_100M);
    rx = 1'b0;
    repeat (300) @(negedge clk_100M);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_clear_byte", {24'd0, rx_byte}, 32'h00);
    checkOutput("async_clear_valid", {31'd0, byte_valid}, 32'd0);
    rx = 1'b1;
    repeat (20) @(negedge clk_100M);
    rst = 1'b1;
    driveBit(1'b1);
    driveBit(1'b1);
    checkOutput("strobes_after_abort", pulses, 32'd4);
    applyStimulus(8'h01, 1'b1);
    driveBit(1'b1);
    checkOutput("pending_01", exp_q.size(), 32'd0);
    checkOutput("byte_01", {24'd0, rx_byte}, 32'h01);
    checkOutput("strobes_total", pulses, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
